tpu_ctrl: RTL and testbench
===========================

TPU_CTRL -- requirements
Module: tpu_ctrl

Interface
REQ-001 Parameter DIM, default 8, systolic array dimension (rows = columns).
REQ-002 Parameter ADDRW, default 16, MMIO address width.
REQ-003 Parameter RUN_CYCLES, default 3*DIM-2, number of array-enable cycles per matmul.
REQ-004 clk  input  1  single clock; all logic updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  1  MMIO access request strobe, held until ack.
REQ-007 r_w  input  1  0 read, 1 write; qualified by req.
REQ-008 addr  input  ADDRW  MMIO address; qualified by req.
REQ-009 ack  output  1  one-cycle access-accepted pulse.
REQ-010 wr_en_a  output  1  A memory row write strobe.
REQ-011 wr_en_b  output  1  B memory write strobe.
REQ-012 wr_en_c  output  1  C row write strobe into array.
REQ-013 a_row  output  $clog2(DIM)  A row select, addr[5:3].
REQ-014 c_row  output  $clog2(DIM)  C row select, addr[6:4].
REQ-015 c_hi  output  1  C half-row select, addr[3].
REQ-016 arr_en  output  1  systolic array / memA advance enable.
REQ-017 b_en  output  1  memB enable, wr_en_b OR arr_en.
REQ-018 busy  output  1  matmul in progress.
REQ-019 done  output  1  one-cycle pulse at matmul completion.

Function
REQ-020 Decode on req: addr[15:8]=0x01 with r_w=1 is A write; 0x02 with r_w=1 is B write; 0x03 is C read or write; addr=0x0400 with r_w=1 is START; anything else is an unmapped access.
REQ-021 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-022 IDLE: an accepted request asserts ack combinationally in the same cycle as req, together with exactly one matching strobe (wr_en_a, wr_en_b, or wr_en_c if r_w=1); row selects follow addr.
REQ-023 A read, B read, or unmapped access in IDLE is acked with no strobe (no hang).
REQ-024 START in IDLE: ack pulses, clear the 5-bit cycle counter, next state RUN.
REQ-025 RUN: arr_en=1 and busy=1 for exactly RUN_CYCLES consecutive cycles; counter increments each cycle; on counter = RUN_CYCLES-1 go to DONE.
REQ-026 DONE: one cycle with done=1, busy=1, arr_en=0; next state IDLE.
REQ-027 In RUN and DONE every req (including START) is stalled: ack=0 and all wr_en_* = 0; a request held through the run is accepted in the first IDLE cycle.
REQ-028 b_en equals wr_en_b OR arr_en in every cycle.
REQ-029 At most one of wr_en_a, wr_en_b, wr_en_c is high in any cycle; no strobe is asserted while arr_en=1.
REQ-030 With req=0, all strobes and ack are 0.
REQ-031 Back-to-back START: a second START held during the run is acked in the first IDLE cycle, and RUN re-enters on the following cycle.

Reset
REQ-032 While rst=1: state IDLE, counter 0; ack, wr_en_*, arr_en, b_en, busy, and done are all 0, overriding req.
REQ-033 Reset asserted mid-RUN aborts the matmul on the next edge with no done pulse.

Configuration
REQ-034 With TPU_CTRL_PERF_EN defined, add output perf_cnt[31:0], cleared by reset and incremented once per arr_en cycle (wraps at 2^32); a read of addr 0x0500 is acked in IDLE.
REQ-035 With TPU_CTRL_PERF_EN undefined, perf_cnt is absent and 0x0500 is an unmapped access.

Verification
REQ-036 A write req at addr 0x0128 in IDLE -> same-cycle ack=1, wr_en_a=1, a_row=5.
REQ-037 START (0x0400, r_w=1) -> arr_en high exactly 22 cycles (DIM=8), then a single done pulse, busy low next cycle.
REQ-038 C write req at 0x0358 held during RUN -> ack=0 and wr_en_c=0 until IDLE, then ack with c_row=5, c_hi=1.
REQ-039 rst=1 at RUN cycle 10 -> next cycle arr_en=0, busy=0, no done pulse; a new START runs the full 22 cycles.
REQ-040 B write req at 0x0207 -> wr_en_b=1 and b_en=1 for one cycle; during RUN b_en=1 with wr_en_b=0.
REQ-041 TPU_CTRL_PERF_EN defined, two matmuls -> perf_cnt=44; undefined -> 0x0500 read acked with no strobe.

Source files
------------

// File: rtl/tpu_ctrl.sv
// MMIO decode and matmul sequencer for a DIM x DIM systolic array.
// Optional build macro TPU_CTRL_PERF_EN adds the perf_cnt array-enable counter.
module tpu_ctrl #(
  parameter int DIM        = 8,
  parameter int ADDRW      = 16,
  parameter int RUN_CYCLES = 3*DIM-2,
  localparam int RW        = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             r_w,
  input  logic [ADDRW-1:0] addr,
  output logic             ack,
  output logic             wr_en_a,
  output logic             wr_en_b,
  output logic             wr_en_c,
  output logic [RW-1:0]    a_row,
  output logic [RW-1:0]    c_row,
  output logic             c_hi,
  output logic             arr_en,
  output logic             b_en,
  output logic             busy,
  output logic             done
`ifdef TPU_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);
  localparam logic [4:0]       CNT_LAST   = 5'(RUN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] page;

  assign page  = addr[15:8];
  assign a_row = addr[3 +: RW];
  assign c_row = addr[4 +: RW];
  assign c_hi  = addr[3];

  // Every request in IDLE is acked, including unmapped and perf reads,
  // so only the strobes depend on the decoded page.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack     = 1'b0;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    wr_en_c = 1'b0;
    arr_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            ack     = 1'b1;
            wr_en_a = r_w && (page == 8'h01);
            wr_en_b = r_w && (page == 8'h02);
            wr_en_c = r_w && (page == 8'h03);
            if (r_w && (addr == START_ADDR)) begin
              cnt_d   = '0;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          arr_en = 1'b1;
          busy   = 1'b1;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
        DONE: begin
          done    = 1'b1;
          busy    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    b_en = wr_en_b | arr_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TPU_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else if (arr_en) perf_q <= perf_q + 32'd1;
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed plus randomized bench for tpu_ctrl against a cycle-count reference model.
module tb_tpu_ctrl;
  localparam int DIM = 8;
  localparam int RC  = 3*DIM-2;

  logic        clk = 1'b0;
  logic        rst, req, r_w;
  logic [15:0] addr;
  logic        ack, wr_en_a, wr_en_b, wr_en_c, arr_en, b_en, busy, done, c_hi;
  logic [2:0]  a_row, c_row;
`ifdef TPU_CTRL_PERF_EN
  logic [31:0] perf_cnt;
`endif

  tpu_ctrl #(.DIM(DIM), .ADDRW(16), .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .req(req), .r_w(r_w), .addr(addr),
    .ack(ack), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_en_c(wr_en_c),
    .a_row(a_row), .c_row(c_row), .c_hi(c_hi), .arr_en(arr_en),
    .b_en(b_en), .busy(busy), .done(done)
`ifdef TPU_CTRL_PERF_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // Model: t = 0 idle, 1..RC array-enable cycles, RC+1 done cycle.
  int t = 0;
  int unsigned perf_m = 0;

  logic c_ack, c_wa, c_wb, c_wc, c_arr, c_ben, c_busy, c_done, c_chi;
  logic [2:0] c_arow, c_crow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic q, input logic w, input logic [15:0] a);
    logic e_ack, ea, eb, ec, e_arr, e_busy, e_done;
    logic [7:0] pg;
    rst = r; req = q; r_w = w; addr = a;
    #1;
    pg = a[15:8];
    e_ack = 0; ea = 0; eb = 0; ec = 0; e_arr = 0; e_busy = 0; e_done = 0;
    if (!r) begin
      if (t == 0) begin
        if (q) begin
          e_ack = 1;
          ea = w && (pg == 8'h01);
          eb = w && (pg == 8'h02);
          ec = w && (pg == 8'h03);
        end
      end else if (t <= RC) begin
        e_arr = 1; e_busy = 1;
      end else begin
        e_done = 1; e_busy = 1;
      end
    end
    c_ack = ack; c_wa = wr_en_a; c_wb = wr_en_b; c_wc = wr_en_c; c_arr = arr_en;
    c_ben = b_en; c_busy = busy; c_done = done; c_arow = a_row; c_crow = c_row; c_chi = c_hi;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("wr_en_a", 32'(wr_en_a), 32'(ea));
    chk("wr_en_b", 32'(wr_en_b), 32'(eb));
    chk("wr_en_c", 32'(wr_en_c), 32'(ec));
    chk("arr_en", 32'(arr_en), 32'(e_arr));
    chk("b_en", 32'(b_en), 32'(eb | e_arr));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (q) begin
      chk("a_row", 32'(a_row), 32'(a[5:3]));
      chk("c_row", 32'(c_row), 32'(a[6:4]));
      chk("c_hi", 32'(c_hi), 32'(a[3]));
    end
`ifdef TPU_CTRL_PERF_EN
    chk("perf_cnt", perf_cnt, perf_m);
`endif
    @(posedge clk);
    #1;
    if (r) begin
      t = 0; perf_m = 0;
    end else begin
      if (e_arr) perf_m++;
      if (t == 0) t = (q && w && a == 16'h0400) ? 1 : 0;
      else if (t == RC + 1) t = 0;
      else t++;
    end
  endtask

  initial begin
    int arr_n, done_n, wc_n, ack_at;
    logic [15:0] ra;

    // Reset overrides a pending START
    for (int i = 0; i < 3; i++) step(1, 1, 1, 16'h0400);
    step(0, 0, 0, 16'h0000);

    // A write at 0x0128
    step(0, 1, 1, 16'h0128);
    chk("a_wr_ack", 32'(c_ack), 1);
    chk("a_wr_strobe", 32'(c_wa), 1);
    chk("a_wr_row", 32'(c_arow), 5);

    // START, then a C write held through the whole run
    step(0, 1, 1, 16'h0400);
    arr_n = 0; done_n = 0; wc_n = 0; ack_at = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 16'h0358);
      if (c_arr) arr_n++;
      if (c_done) done_n++;
      if (c_ack) begin ack_at = i; break; end
      if (c_wc) wc_n++;
    end
    chk("run_len", 32'(arr_n), 22);
    chk("done_pulses", 32'(done_n), 1);
    chk("stall_wr_c", 32'(wc_n), 0);
    chk("held_ack_cycle", 32'(ack_at), 23);
    chk("held_wr_c", 32'(c_wc), 1);
    chk("held_busy", 32'(c_busy), 0);
    chk("held_c_row", 32'(c_crow), 5);
    chk("held_c_hi", 32'(c_chi), 1);

    // B write and read/unmapped accesses
    step(0, 1, 1, 16'h0207);
    chk("b_wr_strobe", 32'(c_wb), 1);
    chk("b_wr_ben", 32'(c_ben), 1);
    step(0, 0, 0, 16'h0207);
    chk("b_ben_after", 32'(c_ben), 0);
    step(0, 1, 0, 16'h0128);
    step(0, 1, 0, 16'h0207);
    step(0, 1, 0, 16'h0358);
    step(0, 1, 0, 16'h0400);
    step(0, 1, 1, 16'h0999);
    step(0, 1, 0, 16'h0500);
    chk("perf_rd_ack", 32'(c_ack), 1);
    chk("perf_rd_nostrobe", 32'({c_wa, c_wb, c_wc}), 0);

    // Reset at RUN cycle 10 aborts, then a full run
    step(0, 1, 1, 16'h0400);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    chk("abort_arr", 32'(c_arr), 0);
    chk("abort_busy", 32'(c_busy), 0);
    chk("abort_done", 32'(c_done), 0);
    step(0, 1, 1, 16'h0400);
    arr_n = 0; done_n = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 16'h0000);
      if (c_arr) arr_n++;
      if (c_done) done_n++;
    end
    chk("rerun_len", 32'(arr_n), 22);
    chk("rerun_done", 32'(done_n), 1);

    // Back-to-back START held through the run
    step(0, 1, 1, 16'h0400);
    ack_at = -1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 16'h0400);
      if (c_ack) begin ack_at = i; break; end
    end
    chk("b2b_ack_cycle", 32'(ack_at), 23);
    step(0, 0, 0, 16'h0000);
    chk("b2b_rerun", 32'(c_arr), 1);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 16'h0000);

    // Two matmuls from reset
    step(1, 0, 0, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 1, 16'h0400);
      for (int i = 0; i < 23; i++) step(0, 0, 0, 16'h0000);
    end
`ifdef TPU_CTRL_PERF_EN
    chk("perf_two_runs", perf_cnt, 44);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 8))
        0: ra = 16'h0128;
        1: ra = 16'h01F0;
        2: ra = 16'h0207;
        3: ra = 16'h0358;
        4: ra = 16'h03A0;
        5, 6: ra = 16'h0400;
        7: ra = 16'h0500;
        default: ra = 16'($urandom);
      endcase
      step(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom), ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
